// File: rtl/unidade_controle.sv
// Multi-cycle MIPS main control FSM: opcode decode plus per-state datapath enables.
// Define UNIDADE_CONTROLE_ADDI_EN to build the addi states (ADDIEX/ADDIWB).
module unidade_controle (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       invalido,
  output logic [3:0] estado
);

  typedef enum logic [3:0] {
    INICIO   = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    REXEC    = 4'd7,
    RWB      = 4'd8,
    BEQ      = 4'd9,
    JUMP     = 4'd10,
    ADDIEX   = 4'd11,
    ADDIWB   = 4'd12,
    ILEGAL   = 4'd13
  } estado_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef UNIDADE_CONTROLE_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  estado_t    estado_q, estado_d;
  logic [1:0] aluop_next;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= INICIO;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = INICIO;
    unique case (estado_q)
      INICIO:   estado_d = FETCH;
      FETCH:    estado_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: estado_d = MEMADR;
          OP_R:         estado_d = REXEC;
          OP_BEQ:       estado_d = BEQ;
          OP_J:         estado_d = JUMP;
`ifdef UNIDADE_CONTROLE_ADDI_EN
          OP_ADDI:      estado_d = ADDIEX;
`endif
          default:      estado_d = ILEGAL;
        endcase
      end
      MEMADR:   estado_d = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  estado_d = MEMWB;
      MEMWB:    estado_d = FETCH;
      MEMWRITE: estado_d = FETCH;
      REXEC:    estado_d = RWB;
      RWB:      estado_d = FETCH;
      BEQ:      estado_d = FETCH;
      JUMP:     estado_d = FETCH;
`ifdef UNIDADE_CONTROLE_ADDI_EN
      ADDIEX:   estado_d = ADDIWB;
      ADDIWB:   estado_d = FETCH;
`endif
      ILEGAL:   estado_d = FETCH;
      default:  estado_d = INICIO;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    invalido    = 1'b0;
    case (estado_q)
      FETCH: begin
        memread = 1'b1;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      DECODE:   alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMREAD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWRITE: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      REXEC:    alusrca = 1'b1;
      RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQ: begin
        alusrca     = 1'b1;
        pcwritecond = 1'b1;
        pcsrc       = 2'b01;
      end
      JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
`ifdef UNIDADE_CONTROLE_ADDI_EN
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:   regwrite = 1'b1;
`endif
      ILEGAL:   invalido = 1'b1;
      default: ;
    endcase
  end

  // aluop follows the state being entered so the registered ALU command lines up with it.
  always_comb begin
    aluop_next = 2'b00;
    case (estado_d)
      REXEC:   aluop_next = 2'b10;
      BEQ:     aluop_next = 2'b01;
      default: aluop_next = 2'b00;
    endcase
  end

  assign aluop  = rst_n ? aluop_next : 2'b00;
  assign estado = estado_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: walks lw, R, beq, j, illegal, addi, sw,
// and an asynchronous reset in MEMWRITE, with a small ALU-control model for comando.
module tb_unidade_controle;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b100011;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, invalido;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] estado;
  logic [5:0] funct = 6'b100000;
  logic [3:0] comando;
  logic [14:0] outs;
  int checks = 0;
  int errors = 0;

  localparam logic [14:0] O_PCW  = 15'h4000;
  localparam logic [14:0] O_PWC  = 15'h2000;
  localparam logic [14:0] O_IORD = 15'h1000;
  localparam logic [14:0] O_MR   = 15'h0800;
  localparam logic [14:0] O_MW   = 15'h0400;
  localparam logic [14:0] O_IRW  = 15'h0200;
  localparam logic [14:0] O_MTR  = 15'h0100;
  localparam logic [14:0] O_RD   = 15'h0080;
  localparam logic [14:0] O_RW   = 15'h0040;
  localparam logic [14:0] O_SA   = 15'h0020;
  localparam logic [14:0] O_SB01 = 15'h0008;
  localparam logic [14:0] O_SB10 = 15'h0010;
  localparam logic [14:0] O_SB11 = 15'h0018;
  localparam logic [14:0] O_PS01 = 15'h0002;
  localparam logic [14:0] O_PS10 = 15'h0004;
  localparam logic [14:0] O_INV  = 15'h0001;
  localparam logic [14:0] O_FETCH = O_PCW | O_MR | O_IRW | O_SB01;

  unidade_controle dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .aluop(aluop), .invalido(invalido), .estado(estado)
  );

  always #5 clk = ~clk;

  assign outs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                 memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc, invalido};

  // Downstream ALU-control stage: registers aluop (and funct) into comando.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) comando <= 4'd0;
    else begin
      case (aluop)
        2'b00:   comando <= 4'b0010;
        2'b01:   comando <= 4'b0110;
        2'b10:   comando <= (funct == 6'b100000) ? 4'b0010 :
                            (funct == 6'b100010) ? 4'b0110 : 4'b1111;
        default: comando <= 4'b1111;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag, input int est, input logic [14:0] o,
                           input logic [1:0] a);
    check({tag, ".estado"}, 32'(estado), 32'(est));
    check({tag, ".outs"},   32'(outs),   32'(o));
    check({tag, ".aluop"},  32'(aluop),  32'(a));
  endtask

  task automatic cycle(input string tag, input int est, input logic [14:0] o,
                       input logic [1:0] a);
    @(negedge clk);
    check_now(tag, est, o, a);
  endtask

  initial begin
    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_now("reset", 0, 15'h0, 2'b00);
    end
    rst_n = 1'b1;
    #1 check_now("release", 0, 15'h0, 2'b00);

    // lw: 1,2,3,4,5
    cycle("lw.fetch",   1, O_FETCH, 2'b00);
    check("lw.fetch.comando", 32'(comando), 32'h2);
    cycle("lw.decode",  2, O_SB11, 2'b00);
    cycle("lw.memadr",  3, O_SA | O_SB10, 2'b00);
    cycle("lw.memread", 4, O_MR | O_IORD, 2'b00);
    cycle("lw.memwb",   5, O_RW | O_MTR, 2'b00);
    opcode = 6'b000000;

    // R-type: aluop=10 issued during DECODE, comando valid in REXEC
    cycle("r.fetch",  1, O_FETCH, 2'b00);
    cycle("r.decode", 2, O_SB11, 2'b10);
    cycle("r.rexec",  7, O_SA, 2'b00);
    check("r.rexec.comando", 32'(comando), 32'h2);
    cycle("r.rwb",    8, O_RW | O_RD, 2'b00);
    opcode = 6'b000100;

    // beq
    cycle("beq.fetch",  1, O_FETCH, 2'b00);
    cycle("beq.decode", 2, O_SB11, 2'b01);
    cycle("beq.beq",    9, O_SA | O_PWC | O_PS01, 2'b00);
    check("beq.comando", 32'(comando), 32'h6);
    opcode = 6'b000010;

    // j
    cycle("j.fetch",  1, O_FETCH, 2'b00);
    cycle("j.decode", 2, O_SB11, 2'b00);
    cycle("j.jump",  10, O_PCW | O_PS10, 2'b00);
    opcode = 6'b111111;

    // illegal opcode: single-cycle invalido then FETCH
    cycle("ill.fetch",  1, O_FETCH, 2'b00);
    cycle("ill.decode", 2, O_SB11, 2'b00);
    cycle("ill.ilegal", 13, O_INV, 2'b00);
    opcode = 6'b001000;

    // addi
    cycle("addi.fetch",  1, O_FETCH, 2'b00);
    check("ill.invalido_cleared", 32'(invalido), 32'h0);
    cycle("addi.decode", 2, O_SB11, 2'b00);
`ifdef UNIDADE_CONTROLE_ADDI_EN
    cycle("addi.ex", 11, O_SA | O_SB10, 2'b00);
    cycle("addi.wb", 12, O_RW, 2'b00);
`else
    cycle("addi.ilegal", 13, O_INV, 2'b00);
`endif
    opcode = 6'b101011;

    // sw, then reset while in MEMWRITE
    cycle("sw.fetch",  1, O_FETCH, 2'b00);
    cycle("sw.decode", 2, O_SB11, 2'b00);
    cycle("sw.memadr", 3, O_SA | O_SB10, 2'b00);
    cycle("sw.memwrite", 6, O_MW | O_IORD, 2'b00);
    rst_n = 1'b0;
    #1 check_now("sw.async_reset", 0, 15'h0, 2'b00);
    check("sw.memwrite_dropped", 32'(memwrite), 32'h0);
    cycle("sw.in_reset", 0, 15'h0, 2'b00);
    rst_n = 1'b1;
    #1 check_now("rerelease", 0, 15'h0, 2'b00);
    opcode = 6'b100011;
    cycle("restart.fetch",  1, O_FETCH, 2'b00);
    cycle("restart.decode", 2, O_SB11, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle main control FSM for the MIPS datapath. It decodes the 6-bit opcode from the instruction register and sequences the per-state datapath enables and mux selects. It also drives the 2-bit `aluop` consumed by the clocked ALU-control stage, which registers `aluop` into the 4-bit ALU `comando`. `aluop` is issued one cycle early so that `comando` is valid during the state that uses it.

## Interface
- No parameters.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 6: instr[31:26] from the instruction register.
- `pcwrite` output 1: unconditional PC write.
- `pcwritecond` output 1: PC write if ALU zero.
- `iord` output 1: memory address select (0 = PC, 1 = ALUOut).
- `memread` output 1: memory read strobe.
- `memwrite` output 1: memory write strobe.
- `irwrite` output 1: instruction register load.
- `memtoreg` output 1: write-back select (1 = MDR).
- `regdst` output 1: destination register select (1 = rd).
- `regwrite` output 1: register file write.
- `alusrca` output 1: ALU A select (0 = PC, 1 = A).
- `alusrcb` output 2: ALU B select (00 B, 01 const 4, 10 signext, 11 signext<<2).
- `pcsrc` output 2: PC source (00 ALU, 01 ALUOut, 10 jump target).
- `aluop` output 2: to ALU control (00 add, 01 sub, 10 funct).
- `invalido` output 1: illegal-opcode flag.
- `estado` output 4: current state code, for debug.

## Operation
- Opcodes: lw 100011, sw 101011, R 000000, beq 000100, j 000010, addi 001000.
- All outputs listed per state; unlisted outputs are 0.
- 0 INICIO: all outputs 0. Next state is FETCH.
- 1 FETCH: memread, irwrite, pcwrite, alusrcb=01, aluop=00. Next state is DECODE.
- 2 DECODE: alusrcb=11, aluop=00. Next state by opcode:
  - lw/sw → MEMADR
  - R → REXEC
  - beq → BEQ
  - j → JUMP
  - addi → ADDIEX
  - anything else → ILEGAL
- 3 MEMADR: alusrca=1, alusrcb=10, aluop=00. lw → MEMREAD; sw → MEMWRITE.
- 4 MEMREAD: memread, iord. Next state is MEMWB.
- 5 MEMWB: regwrite, memtoreg, regdst=0. Next state is FETCH.
- 6 MEMWRITE: memwrite, iord. Next state is FETCH.
- 7 REXEC: alusrca=1, alusrcb=00, aluop=10. Next state is RWB.
- 8 RWB: regwrite, regdst=1. Next state is FETCH.
- 9 BEQ: alusrca=1, alusrcb=00, aluop=01, pcwritecond, pcsrc=01. Next state is FETCH.
- 10 JUMP: pcwrite, pcsrc=10. Next state is FETCH.
- 11 ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next state is ADDIWB.
- 12 ADDIWB: regwrite, regdst=0, memtoreg=0. Next state is FETCH.
- 13 ILEGAL: invalido=1. Next state is FETCH; the PC has already advanced, so the illegal word is skipped.
- 14, 15: unreachable. Next state is INICIO, with all outputs 0.

## Timing
- State register updates on the rising edge of `clk`.
- Async reset: state goes to INICIO immediately, `estado` = 0.
- All outputs except `aluop` are Moore-decoded from the current state. Their reset value is 0.
- `aluop` is decoded from the next state, i.e. the aluop of the state being entered:
  - The ALU-control stage registers it at the edge that enters state S, so `comando` matches S throughout S.
  - While `rst_n` = 0, `aluop` is forced to 00.
- `opcode` is sampled only in DECODE and MEMADR. It must be stable from the end of FETCH until the next FETCH.
- Instruction cycle counts, FETCH to FETCH: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 3.
- First FETCH occurs one cycle after `rst_n` rises.
- Reset mid-instruction: any in-flight write strobe drops asynchronously; no partial write-back occurs.
- `memwrite` and `regwrite` are never high in the same cycle.
- `invalido` is a single-cycle pulse.

## Configuration
- `UNIDADE_CONTROLE_ADDI_EN`:
  - Defined: addi is decoded, DECODE → ADDIEX → ADDIWB.
  - Undefined: states 11/12 are not built and addi (001000) goes to ILEGAL; encodings 11/12 go to INICIO like 14/15.

## Test plan
- Reset release: `rst_n` low for 3 cycles, then high → all outputs 0 during reset; `estado` 0 then 1 (FETCH), then 2; `aluop` = 00 in both.
- lw (100011) → `estado` sequence 1,2,3,4,5,1; `regwrite` = `memtoreg` = 1 only in state 5; `iord` = 1 only in state 4.
- R-type (000000) → `aluop` = 10 is already present on the edge entering state 7, so `comando` for funct 100000 is 0010 during REXEC; `regdst` = `regwrite` = 1 in state 8.
- beq then j → beq: state 9 with `aluop` = 01, `pcwritecond` = 1, `pcsrc` = 01. j: state 10 with `pcwrite` = 1, `pcsrc` = 10.
- Opcode 111111, plus addi with the macro undefined → state 13, `invalido` high for exactly one cycle, then FETCH.
- Reset asserted during MEMWRITE (state 6) → `memwrite` drops within the same cycle, `estado` = 0; after release the sequence restarts at FETCH.
